// File: rtl/pkt_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pkt_ctrl_pkg
// Brief    : Shared state encoding and default widths for the packet send path.
// Revision : 1.0
// ============================================================================
package pkt_ctrl_pkg;

  localparam int unsigned DFX_WIDTH_DEF     = 2;
  localparam int unsigned SEQ_NUM_WIDTH_DEF = 1;

  localparam int unsigned STATE_W = 3;
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_START      = 3'd1;
  localparam logic [2:0] ST_WAIT_ENCAP = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK   = 3'd3;
  localparam logic [2:0] ST_ERR        = 3'd4;

  // Bits needed to hold values 0..max_val (never less than one).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ack_timer.sv
`default_nettype none
// ============================================================================
// Module   : ack_timer
// Brief    : ACK wait counter; expired flags the last allowed wait cycle.
// Revision : 1.0
// ============================================================================
module ack_timer
  import pkt_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at the last value so a stalled enable cannot wrap into a false expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != C_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/pkt_send_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pkt_send_ctrl
// Brief    : Packet send controller with ACK timeout replay.
//            PKT_SEND_RETRY_LIMIT_EN enables the per-packet replay limit / ERR.
// Revision : 1.0
// ============================================================================
module pkt_send_ctrl
  import pkt_ctrl_pkg::*;
#(
  parameter int unsigned DFX_WIDTH      = DFX_WIDTH_DEF,
  parameter int unsigned SEQ_NUM_WIDTH  = SEQ_NUM_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     send_req,
  input  logic [DFX_WIDTH-1:0]     send_dst_dfx,
  input  logic [DFX_WIDTH-1:0]     local_dfx,
  output logic                     send_ready,
  output logic                     start_encap_pkt,
  output logic [DFX_WIDTH-1:0]     pkt_src_dfx,
  output logic [DFX_WIDTH-1:0]     pkt_dst_dfx,
  output logic [SEQ_NUM_WIDTH-1:0] pkt_sn,
  input  logic                     done_encap_pkt,
  output logic                     replay_pkt_sent,
  input  logic                     ack_valid,
  input  logic [SEQ_NUM_WIDTH-1:0] ack_sn,
  output logic                     send_done,
  output logic                     send_err
);

`ifdef PKT_SEND_RETRY_LIMIT_EN
  localparam logic C_RETRY_LIMIT_EN = 1'b1;
`else
  localparam logic C_RETRY_LIMIT_EN = 1'b0;
`endif

  localparam int unsigned RETRY_W = cnt_width(MAX_RETRY);
  localparam logic [RETRY_W-1:0] C_MAX_RETRY = RETRY_W'(MAX_RETRY);

  logic [STATE_W-1:0]       state_q, state_d;
  logic [DFX_WIDTH-1:0]     src_q, src_d, dst_q, dst_d;
  logic [SEQ_NUM_WIDTH-1:0] sn_q, sn_d;
  logic [RETRY_W-1:0]       retry_q, retry_d;
  logic                     replay_q, replay_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic accept, ack_match, expired, retry_stop, timer_clear, timer_en;

  assign accept      = send_req && (state_q == ST_IDLE);
  assign ack_match   = (state_q == ST_WAIT_ACK) && ack_valid && (ack_sn == sn_q);
  assign timer_clear = (state_q == ST_WAIT_ENCAP) && done_encap_pkt;
  assign timer_en    = (state_q == ST_WAIT_ACK);
  assign retry_stop  = C_RETRY_LIMIT_EN && (retry_q == C_MAX_RETRY);

  ack_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_ack_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(expired)
  );

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    sn_d     = sn_q;
    retry_d  = retry_q;
    err_d    = err_q;
    replay_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_START;
          src_d   = local_dfx;
          dst_d   = send_dst_dfx;
          retry_d = '0;
        end
      end
      ST_START:      state_d = ST_WAIT_ENCAP;
      ST_WAIT_ENCAP: if (done_encap_pkt) state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        // A matching ACK wins over a coincident expiry.
        if (ack_match) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          sn_d    = sn_q + SEQ_NUM_WIDTH'(1);
        end else if (expired) begin
          if (retry_stop) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            state_d  = ST_START;
            replay_d = 1'b1;
            if (retry_q != C_MAX_RETRY) retry_d = retry_q + RETRY_W'(1);
          end
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      sn_q     <= '0;
      retry_q  <= '0;
      replay_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      sn_q     <= sn_d;
      retry_q  <= retry_d;
      replay_q <= replay_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Ready is held low while reset is asserted so every output reads 0 in reset.
  assign send_ready      = rst_n && (state_q == ST_IDLE);
  assign start_encap_pkt = (state_q == ST_START) || (state_q == ST_WAIT_ENCAP);
  assign pkt_src_dfx     = src_q;
  assign pkt_dst_dfx     = dst_q;
  assign pkt_sn          = sn_q;
  assign replay_pkt_sent = replay_q;
  assign send_done       = done_q;
  assign send_err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pkt_send_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pkt_send_ctrl
// Brief    : Scoreboard bench for pkt_send_ctrl with a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_pkt_send_ctrl;

  localparam int DW   = 2;
  localparam int SW   = 1;
  localparam int TMO  = 256;
  localparam int MAXR = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          send_req = 1'b0;
  logic [DW-1:0] send_dst_dfx = '0;
  logic [DW-1:0] local_dfx = '0;
  logic          send_ready;
  logic          start_encap_pkt;
  logic [DW-1:0] pkt_src_dfx, pkt_dst_dfx;
  logic [SW-1:0] pkt_sn;
  logic          done_encap_pkt = 1'b0;
  logic          replay_pkt_sent;
  logic          ack_valid = 1'b0;
  logic [SW-1:0] ack_sn = '0;
  logic          send_done;
  logic          send_err;

  always #5 clk = ~clk;

  pkt_send_ctrl #(
    .DFX_WIDTH(DW), .SEQ_NUM_WIDTH(SW), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .send_req(send_req), .send_dst_dfx(send_dst_dfx),
    .local_dfx(local_dfx), .send_ready(send_ready), .start_encap_pkt(start_encap_pkt),
    .pkt_src_dfx(pkt_src_dfx), .pkt_dst_dfx(pkt_dst_dfx), .pkt_sn(pkt_sn),
    .done_encap_pkt(done_encap_pkt), .replay_pkt_sent(replay_pkt_sent),
    .ack_valid(ack_valid), .ack_sn(ack_sn), .send_done(send_done), .send_err(send_err)
  );

  typedef struct {
    bit            is_done;
    logic [DW-1:0] src;
    logic [DW-1:0] dst;
    logic [SW-1:0] sn;      // header sn for a start, next sn for a done
    bit            replay;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [SW-1:0] model_sn = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic flag(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitor: every start rising edge or send_done pulse consumes one expectation.
  logic start_prev = 1'b0;
  always @(negedge clk) begin
    bit   rise;
    exp_t e;
    rise = start_encap_pkt && !start_prev;
    start_prev = start_encap_pkt;
    if (rst_n) begin
      if (rise || send_done) begin
        if (exp_q.size() == 0) begin
          flag("unexpected_output", $sformatf("start_rise=%0b send_done=%0b, required none", rise, send_done));
        end else begin
          e = exp_q.pop_front();
          check("event_is_done", send_done, e.is_done);
          if (!e.is_done) begin
            check("start_src", pkt_src_dfx, e.src);
            check("start_dst", pkt_dst_dfx, e.dst);
            check("start_sn", pkt_sn, e.sn);
            check("start_replay_flag", replay_pkt_sent, e.replay);
          end else begin
            check("sn_after_done", pkt_sn, e.sn);
          end
        end
      end
      if (replay_pkt_sent && !rise)
        flag("replay_without_start", "replay_pkt_sent=1 with no start edge, required 0");
    end
  end

  task automatic wait_start(input int budget);
    int t = 0;
    while (!start_encap_pkt && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (!start_encap_pkt) flag("start_wait", "start_encap_pkt stayed 0, required 1");
  endtask

  task automatic wait_ready(input int budget);
    int t = 0;
    while (!send_ready && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (!send_ready) flag("ready_wait", "send_ready stayed 0, required 1");
  endtask

  // One packet: ntmo timeouts, then an ACK at WAIT_ACK cycle index ack_k (ack_k<0: never).
  task automatic send_pkt(input logic [DW-1:0] dst, input logic [DW-1:0] lcl,
                          input int ntmo, input int ack_k, input int dly, input bit noise);
    int cur;
    wait_ready(TMO + 50);
    send_req = 1'b1; send_dst_dfx = dst; local_dfx = lcl;
    exp_q.push_back('{is_done: 1'b0, src: lcl, dst: dst, sn: model_sn, replay: 1'b0});
    @(negedge clk);
    send_req = 1'b0;
    send_dst_dfx = DW'($urandom);
    for (int a = 0; a <= ntmo; a++) begin
      wait_start(TMO + 20);
      if (noise) begin
        ack_valid = 1'b1; ack_sn = model_sn;   // outside WAIT_ACK: ignored
      end
      repeat (dly) begin
        @(negedge clk);
        ack_valid = 1'b0;
      end
      done_encap_pkt = 1'b1;
      @(negedge clk);
      done_encap_pkt = 1'b0;
      cur = 0;
      if (noise) begin
        done_encap_pkt = 1'b1;                 // stray done in WAIT_ACK
        ack_valid = 1'b1; ack_sn = ~model_sn;  // wrong sequence number
        @(negedge clk);
        done_encap_pkt = 1'b0; ack_valid = 1'b0;
        cur = 1;
      end
      if (a < ntmo) begin
        exp_q.push_back('{is_done: 1'b0, src: lcl, dst: dst, sn: model_sn, replay: 1'b1});
      end else if (ack_k < 0) begin
        repeat (TMO + 4) @(negedge clk);
      end else begin
        repeat (ack_k - cur) @(negedge clk);
        ack_valid = 1'b1; ack_sn = model_sn;
        exp_q.push_back('{is_done: 1'b1, src: lcl, dst: dst, sn: SW'(model_sn + 1), replay: 1'b0});
        model_sn = SW'(model_sn + 1);
        @(negedge clk);
        ack_valid = 1'b0;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, send_ready, 0);
    check({tag, "_start"}, start_encap_pkt, 0);
    check({tag, "_src"}, pkt_src_dfx, 0);
    check({tag, "_dst"}, pkt_dst_dfx, 0);
    check({tag, "_sn"}, pkt_sn, 0);
    check({tag, "_replay"}, replay_pkt_sent, 0);
    check({tag, "_done"}, send_done, 0);
    check({tag, "_err"}, send_err, 0);
  endtask

  initial begin
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", send_ready, 1);

    // Normal send, dst=10 local=01, done after 3 cycles, ACK sn 0.
    send_pkt(2'b10, 2'b01, 0, 4, 3, 1'b0);
    check("normal_sn_incr", pkt_sn, 1);
    check("normal_src_held", pkt_src_dfx, 2'b01);
    check("normal_dst_held", pkt_dst_dfx, 2'b10);

    // Wrap-around back to sn 0.
    send_pkt(2'b11, 2'b01, 0, 2, 1, 1'b0);
    check("sn_wrap", pkt_sn, 0);

    // Timeout with replay, then ACK.
    send_pkt(2'b10, 2'b01, 1, 3, 2, 1'b0);
    // Wrong ACK first, correct one later.
    send_pkt(2'b01, 2'b10, 0, 8, 2, 1'b1);
    // Matching ACK exactly in the expiry cycle.
    send_pkt(2'b00, 2'b11, 0, TMO - 1, 2, 1'b0);

    for (int i = 0; i < 14; i++) begin
      send_pkt(DW'($urandom), DW'($urandom), ($urandom_range(0, 5) == 0) ? 1 : 0,
               ($urandom_range(0, 4) == 0) ? TMO - 1 : int'($urandom_range(1, 30)),
               int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)));
    end

`ifdef PKT_SEND_RETRY_LIMIT_EN
    send_pkt(2'b11, 2'b00, MAXR, -1, 2, 1'b0);
    check("err_set", send_err, 1);
    check("err_ready_low", send_ready, 0);
    repeat (20) @(negedge clk);
    check("err_sticky", send_err, 1);
    check("err_hold_ready", send_ready, 0);
    check("err_no_start", start_encap_pkt, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("err_cleared", send_err, 0);
    check("err_ready_back", send_ready, 1);
    model_sn = '0;
`else
    send_pkt(2'b11, 2'b00, MAXR + 1, 5, 2, 1'b0);
    check("no_limit_err", send_err, 0);
`endif

    // Reset while waiting for the ACK.
    wait_ready(TMO + 50);
    send_req = 1'b1; send_dst_dfx = 2'b01; local_dfx = 2'b10;
    exp_q.push_back('{is_done: 1'b0, src: 2'b10, dst: 2'b01, sn: model_sn, replay: 1'b0});
    @(negedge clk);
    send_req = 1'b0;
    wait_start(20);
    repeat (2) @(negedge clk);
    done_encap_pkt = 1'b1;
    @(negedge clk);
    done_encap_pkt = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_sn = '0;
    @(negedge clk);
    check("midreset_ready", send_ready, 1);
    check("midreset_sn", pkt_sn, 0);
    ack_valid = 1'b1; ack_sn = '0;      // stale ACK after reset: no done
    @(negedge clk);
    ack_valid = 1'b0;
    repeat (5) @(negedge clk);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pkt_send_ctrl.md
PKT_SEND_CTRL -- requirements
Module: pkt_send_ctrl

Interface
REQ-001 SHALL have parameter DFX_WIDTH, default 2, meaning the DFX node address width.
REQ-002 SHALL have parameter SEQ_NUM_WIDTH, default 1, meaning the packet sequence number width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning the ACK wait limit in clock cycles before a replay.
REQ-004 SHALL have parameter MAX_RETRY, default 3, meaning the replay limit used only under the configuration macro.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port send_req, input, 1 bit: the upstream request to send the currently latched DFX data.
REQ-008 SHALL have port send_dst_dfx, input, DFX_WIDTH bits: the destination, sampled when send_req is accepted.
REQ-009 SHALL have port local_dfx, input, DFX_WIDTH bits: the own node address, driven quasi-static.
REQ-010 SHALL have port send_ready, output, 1 bit: high only in IDLE, and a request is accepted when send_req and send_ready are both high.
REQ-011 SHALL have port start_encap_pkt, output, 1 bit: the level-style start to the encapsulator.
REQ-012 SHALL have ports pkt_src_dfx and pkt_dst_dfx, outputs, DFX_WIDTH bits each, plus pkt_sn, output, SEQ_NUM_WIDTH bits: the packet header fields.
REQ-013 SHALL have port done_encap_pkt, input, 1 bit: the encapsulator completion pulse.
REQ-014 SHALL have port replay_pkt_sent, output, 1 bit: a one-cycle pulse marking that the start just issued is a replay.
REQ-015 SHALL have ports ack_valid, input, 1 bit, and ack_sn, input, SEQ_NUM_WIDTH bits: the returned acknowledgement.
REQ-016 SHALL have ports send_done, output, 1 bit (one-cycle pulse on acknowledged delivery), and send_err, output, 1 bit (sticky; macro only, otherwise tied 0).

Function
REQ-017 SHALL implement the states IDLE, START, WAIT_ENCAP, WAIT_ACK and ERR.
- IDLE -> START on an accepted request.
- START -> WAIT_ENCAP unconditionally.
- WAIT_ENCAP -> WAIT_ACK on done_encap_pkt.
- WAIT_ACK -> IDLE on a matching ACK.
- WAIT_ACK -> START on timeout (replay).
REQ-018 SHALL, on acceptance, register pkt_dst_dfx <= send_dst_dfx and pkt_src_dfx <= local_dfx; both SHALL hold until the next acceptance.
REQ-019 SHALL drive start_encap_pkt high in START and WAIT_ENCAP, and low otherwise, which guarantees at least 1 low cycle between consecutive starts (a rising edge is required by the encapsulator).
REQ-020 SHALL ignore done_encap_pkt in any state other than WAIT_ENCAP.
REQ-021 SHALL clear the timeout counter on entry to WAIT_ACK and increment it once per cycle there; timeout occurs when the count equals TIMEOUT_CYCLES-1 with no matching ACK in that cycle.
REQ-022 SHALL treat an ACK as matching when ack_valid=1 and ack_sn==pkt_sn in WAIT_ACK.
- On a match: pulse send_done, increment pkt_sn modulo 2^SEQ_NUM_WIDTH (wrap-around), and go to IDLE.
REQ-023 SHALL drop non-matching ACKs, and any ACK outside WAIT_ACK, with no effect.
REQ-024 SHALL give priority to the ACK when a matching ACK and the timeout occur in the same cycle: no replay.
REQ-025 SHALL, on a replay, keep pkt_sn, pkt_src_dfx and pkt_dst_dfx unchanged and pulse replay_pkt_sent in the START cycle.
REQ-026 SHALL have a minimum latency from acceptance to start_encap_pkt=1 of 1 cycle (registered output).

Reset
REQ-027 SHALL, when rst_n is low, asynchronously force state IDLE and clear all registers, counters and outputs, including pkt_sn and send_err.
- A reset mid-transfer abandons the packet, and no send_done is produced.

Configuration
REQ-028 SHALL, with PKT_SEND_RETRY_LIMIT_EN defined, count replays per packet.
- A timeout once MAX_RETRY replays have occurred SHALL go to ERR.
- In ERR: send_err=1, send_ready=0, and the state SHALL hold until reset.
REQ-029 SHALL, without PKT_SEND_RETRY_LIMIT_EN, replay indefinitely, with ERR unreachable and send_err constant 0.

Structure
REQ-030 SHALL place the state encoding and the default widths (DFX_WIDTH, SEQ_NUM_WIDTH) in the shared package pkt_ctrl_pkg.
REQ-031 SHALL implement the timeout counter as a sub-module ack_timer (inputs clear and enable, output expired).

Verification
REQ-032 SHALL cover this normal send: send_req with dst=2'b10 and local=2'b01, then done after 3 cycles, then ack_sn=0.
- Required response: pkt_src/dst=01/10, pkt_sn=0, one send_done pulse, pkt_sn becomes 1.
REQ-033 SHALL cover a timeout: no ACK for 256 cycles -> replay_pkt_sent pulse and a second start_encap_pkt rising edge, with pkt_sn still 0.
REQ-034 SHALL cover a wrong ACK: ack_sn=1 while waiting for sn 0 -> ignored, and ack_sn=0 later -> send_done.
REQ-035 SHALL cover a simultaneous event: a matching ACK in the expiry cycle -> send_done and no replay_pkt_sent.
REQ-036 SHALL cover the retry limit with the macro defined and MAX_RETRY=3: 4 timeouts -> send_err=1 and send_ready=0 until reset.
REQ-037 SHALL cover reset during WAIT_ACK: all outputs 0, send_ready=1 after release, pkt_sn=0.
